// File: rtl/psd_pkg.sv
// Shared arithmetic-unit definitions: default operand width and the
// multiplier/divider sequencer state encoding.
package psd_pkg;

    localparam int PSD_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } psd_mul_state_t;

endpackage

// File: rtl/psd_addshift_step.sv
// One shift-add multiplication step: conditionally accumulate the shifted
// multiplicand, then advance multiplicand left and multiplier right.
module psd_addshift_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [2*WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic [2*WIDTH-1:0] acc_next,
    output logic [2*WIDTH-1:0] mcand_next,
    output logic [WIDTH-1:0]   mplier_next
);

    // Partial products never exceed 2*WIDTH bits, so the sum cannot wrap.
    assign acc_next    = mplier[0] ? acc + mcand : acc;
    assign mcand_next  = mcand << 1;
    assign mplier_next = mplier >> 1;

endmodule

// File: rtl/psdmultiply.sv
// Sequential unsigned shift-add multiplier, one multiplier bit per clock.
// Define PSDMULT_EARLY_EXIT_EN to finish as soon as the multiplier is exhausted.
module psdmultiply
    import psd_pkg::*;
#(
    parameter int WIDTH = PSD_WIDTH
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    psd_mul_state_t     state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      count;

    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] mcand_next;
    logic [WIDTH-1:0]   mplier_next;
    logic               last_step;

    psd_addshift_step #(.WIDTH(WIDTH)) u_step (
        .acc         (acc),
        .mcand       (mcand),
        .mplier      (mplier),
        .acc_next    (acc_next),
        .mcand_next  (mcand_next),
        .mplier_next (mplier_next)
    );

`ifdef PSDMULT_EARLY_EXIT_EN
    // Termination is decided purely by an exhausted multiplier; count only tracks progress.
    assign last_step = (mplier == '0);
`else
    assign last_step = (count == CW'(WIDTH - 1));
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            done    <= 1'b0;
            product <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            count   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, multiplicand};
                        mplier <= multiplier;
                        acc    <= '0;
                        count  <= '0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
`ifdef PSDMULT_EARLY_EXIT_EN
                    if (last_step) begin
                        state <= DONE;
                    end else begin
                        acc    <= acc_next;
                        mcand  <= mcand_next;
                        mplier <= mplier_next;
                        count  <= count + 1'b1;
                    end
`else
                    acc    <= acc_next;
                    mcand  <= mcand_next;
                    mplier <= mplier_next;
                    count  <= count + 1'b1;
                    if (last_step)
                        state <= DONE;
`endif
                end
                DONE: begin
                    product <= acc;
                    done    <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_psdmultiply.sv
// Self-checking bench for psdmultiply: cycle-level behavioural model plus
// directed literal checks and randomized operand streams.
module tb_psdmultiply;

    localparam int W = 32;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   multiplicand = '0;
    logic [W-1:0]   multiplier = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clock = ~clock;

    psdmultiply #(.WIDTH(W)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    // Edges from the accepting edge until done/product update.
    function automatic int exp_lat(input logic [W-1:0] b);
`ifdef PSDMULT_EARLY_EXIT_EN
        int msb;
        msb = -1;
        for (int i = 0; i < W; i++)
            if (b[i]) msb = i;
        return msb + 3;
`else
        return W + 1;
`endif
    endfunction

    // Behavioural model: an accepted start schedules A*B to appear exactly
    // exp_lat edges later; busy spans the whole pending interval.
    longint         cyc = 0;
    bit             m_pend = 1'b0;
    bit             m_done = 1'b0;
    longint         m_fin = 0;
    logic [2*W-1:0] m_res = '0;
    logic [2*W-1:0] m_prod = '0;

    always @(posedge clock) begin
        logic [2*W-1:0] a64, b64;
        cyc++;
        m_done = 1'b0;
        if (reset) begin
            m_pend = 1'b0;
            m_prod = '0;
        end else if (m_pend && cyc == m_fin) begin
            m_pend = 1'b0;
            m_done = 1'b1;
            m_prod = m_res;
        end else if (!m_pend && start) begin
            a64    = {{W{1'b0}}, multiplicand};
            b64    = {{W{1'b0}}, multiplier};
            m_pend = 1'b1;
            m_fin  = cyc + exp_lat(multiplier);
            m_res  = a64 * b64;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            tests++;
            if (busy !== m_pend || done !== m_done || product !== m_prod) begin
                fails++;
                $display("FAIL model_cmp cyc=%0d busy=%b/%b done=%b/%b product=%h required %h",
                         cyc, busy, m_pend, done, m_done, product, m_prod);
            end
        end
    end

    task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Called just after a negedge; leaves the bench just after the next negedge.
    task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b);
        start        = 1'b1;
        multiplicand = a;
        multiplier   = b;
        @(posedge clock);
        @(negedge clock);
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
    endtask

    // Counts edges until done is seen; returns -1 on timeout (recorded as a failure).
    task automatic wait_done(input string name, output int lat);
        lat = 0;
        do begin
            @(posedge clock);
            lat++;
            @(negedge clock);
        end while (!done && lat < 200);
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL %s timeout waiting for done after %0d edges", name, lat);
            lat = -1;
        end
    endtask

    initial begin
        int lat;
        int done_seen;
        logic [W-1:0] a, b;

        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_product", product, 64'd0);
        reset  = 1'b0;
        chk_en = 1'b1;
        @(negedge clock);

        // 7 x 6
        do_start(32'd7, 32'd6);
        chk("t1_busy", {63'd0, busy}, 64'd1);
        wait_done("t1", lat);
        chk("t1_product", product, 64'd42);
        chk("t1_latency", 64'(lat), 64'(exp_lat(32'd6)));
`ifndef PSDMULT_EARLY_EXIT_EN
        chk("t1_latency_lit", 64'(lat), 64'd33);
`endif
        @(negedge clock);

        do_start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("t2", lat);
        chk("t2_product", product, 64'hFFFF_FFFE_0000_0001);

        do_start(32'd0, 32'h1234_5678);
        wait_done("t3a", lat);
        chk("t3a_product", product, 64'd0);

        do_start(32'h1234_5678, 32'd1);
        wait_done("t3b", lat);
        chk("t3b_product", product, 64'h0000_0000_1234_5678);
        chk("t3b_latency", 64'(lat), 64'(exp_lat(32'd1)));

        // Start during busy is ignored; start during done is accepted.
        do_start(32'd100, 32'h8000_00C8);
        repeat (4) @(posedge clock);
        @(negedge clock);
        do_start(32'd9, 32'd9);
        wait_done("t4a", lat);
        chk("t4a_product", product, 64'd100 * 64'h8000_00C8);
        do_start(32'd5, 32'd11);
        wait_done("t4b", lat);
        chk("t4b_product", product, 64'd55);
        chk("t4b_latency", 64'(lat), 64'(exp_lat(32'd11)));

        // Reset mid-operation aborts without a done pulse.
        do_start(32'd7, 32'hF000_0000);
        repeat (9) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("t5_busy", {63'd0, busy}, 64'd0);
        chk("t5_done", {63'd0, done}, 64'd0);
        chk("t5_product", product, 64'd0);
        done_seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) done_seen++;
        end
        chk("t5_no_done", 64'(done_seen), 64'd0);

`ifdef PSDMULT_EARLY_EXIT_EN
        do_start(32'd77, 32'd0);
        wait_done("t6a", lat);
        chk("t6a_latency", 64'(lat), 64'd2);
        chk("t6a_product", product, 64'd0);
        do_start(32'd3, 32'h8000_0000);
        wait_done("t6b", lat);
        chk("t6b_latency", 64'(lat), 64'd34);
        chk("t6b_product", product, 64'h1_8000_0000);
`endif

        // Randomized operands, mixing back-to-back starts and idle gaps.
        for (int n = 0; n < 30; n++) begin
            a = $urandom;
            b = $urandom;
            if (n % 3 == 1) b = b >> $urandom_range(0, 31);
            if (n % 7 == 3) a = '0;
            do_start(a, b);
            wait_done("rand", lat);
            chk("rand_product", product, {{W{1'b0}}, a} * {{W{1'b0}}, b});
            if ($urandom_range(0, 1) == 1)
                repeat ($urandom_range(1, 3)) @(negedge clock);
        end

        repeat (3) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
